// File: rtl/alu_rs_station_if.sv
// Shared bus types and the dispatch/CDB/issue bundle for the ALU reservation station.
// Types are sized for a 32-entry ROB (5-bit tags), 32-bit operands and 3-bit ALU opcodes.
// Handshake: dispatch is gated by rs_full, issue is gated by alu_ready.
package alu_rs_pkg;

  localparam int ROB_W    = 5;
  localparam int VAL_W    = 32;
  localparam int OP_W     = 3;
  localparam int RS_SEL_W = 4;

  // Dispatch request from the instruction queue (89 bits).
  typedef struct packed {
    logic                load_RS;
    logic [RS_SEL_W-1:0] RS_sel;
    logic [ROB_W-1:0]    dest_rob;
    logic [OP_W-1:0]     alu_ops;
    logic [ROB_W-1:0]    src1_rob;
    logic [VAL_W-1:0]    src1_value;
    logic                src1_valid;
    logic [ROB_W-1:0]    src2_rob;
    logic [VAL_W-1:0]    src2_value;
    logic                src2_valid;
  } IQtoRS;

  // One common-data-bus result broadcast (38 bits).
  typedef struct packed {
    logic [ROB_W-1:0] dest_rob;
    logic [VAL_W-1:0] value;
    logic             valid;
  } data_bus;

  // Issue toward the ALU (73 bits).
  typedef struct packed {
    logic             ld_alu;
    logic [ROB_W-1:0] rob_idx;
    logic [OP_W-1:0]  alu_op;
    logic [VAL_W-1:0] alu_src1;
    logic [VAL_W-1:0] alu_src2;
  } RStoALU;

  // Station entry; branch and pc fields are not carried because the ALU station keeps them at 0.
  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] dest_rob;
    logic [OP_W-1:0]  alu_ops;
    logic [ROB_W-1:0] src1_rob;
    logic [VAL_W-1:0] src1_value;
    logic             src1_valid;
    logic [ROB_W-1:0] src2_rob;
    logic [VAL_W-1:0] src2_value;
    logic             src2_valid;
  } Reservation_st;

endpackage

interface alu_rs_station_if #(
  parameter int NUM_CDB = 3
);
  import alu_rs_pkg::*;

  logic    flush;
  IQtoRS   iq_in;
  logic    rs_full;
  data_bus cdb_in [NUM_CDB];
  logic    alu_ready;
  RStoALU  alu_out;

  // Dispatch/CDB/ALU side driving the station.
  modport master (output flush, output iq_in, output cdb_in, output alu_ready,
                  input rs_full, input alu_out);

  // The reservation station itself.
  modport slave (input flush, input iq_in, input cdb_in, input alu_ready,
                 output rs_full, output alu_out);

endinterface

// File: rtl/alu_rs_station.sv
// ALU reservation station: holds dispatched ops, wakes operands from the CDBs, issues oldest-slot-first.
// Latency: a dispatched op with ready operands issues 2 cycles after dispatch; a CDB wakeup adds 2 cycles.
// Backpressure: rs_full blocks dispatch; alu_ready=0 holds all ready ops in place while wakeups continue.
module alu_rs_station
  import alu_rs_pkg::*;
#(
  parameter int                  NUM_ENTRIES = 4,
  parameter int                  NUM_CDB     = 3,
  parameter logic [RS_SEL_W-1:0] RS_ID       = 4'd0
) (
  input logic             clk,
  input logic             rst,
  alu_rs_station_if.slave rs_if
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  Reservation_st            entries [NUM_ENTRIES];
  RStoALU                   alu_out_q;
  logic [NUM_ENTRIES-1:0]   valid_vec;
  logic                     full;
  logic [IDX_W-1:0]         free_idx;
  logic [IDX_W-1:0]         ready_idx;
  logic                     ready_found;
  logic                     alloc;
  logic [NUM_ENTRIES-1:0]   s1_hit;
  logic [NUM_ENTRIES-1:0]   s2_hit;
  logic [VAL_W-1:0]         s1_val [NUM_ENTRIES];
  logic [VAL_W-1:0]         s2_val [NUM_ENTRIES];
  logic                     d1_hit;
  logic                     d2_hit;
  logic [VAL_W-1:0]         d1_val;
  logic [VAL_W-1:0]         d2_val;
  Reservation_st            new_entry;

  // Priority encoders over registered entry state: lowest free slot and lowest ready slot.
  always_comb begin
    valid_vec   = '0;
    free_idx    = '0;
    ready_idx   = '0;
    ready_found = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      valid_vec[i] = entries[i].valid;
      if (!entries[i].valid) begin
        free_idx = IDX_W'(i);
      end
      if (entries[i].valid && entries[i].src1_valid && entries[i].src2_valid) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
  end

  assign full          = &valid_vec;
  assign rs_if.rs_full = full;
  assign rs_if.alu_out = alu_out_q;
  assign alloc         = rs_if.iq_in.load_RS && (rs_if.iq_in.RS_sel == RS_ID) && !full;

  // CDB tag match for every waiting operand and for the incoming dispatch; lowest port wins.
  always_comb begin
    d1_hit = 1'b0;
    d2_hit = 1'b0;
    d1_val = '0;
    d2_val = '0;
    s1_hit = '0;
    s2_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      s1_val[i] = '0;
      s2_val[i] = '0;
    end
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (rs_if.cdb_in[k].valid) begin
        if (rs_if.cdb_in[k].dest_rob == rs_if.iq_in.src1_rob) begin
          d1_hit = 1'b1;
          d1_val = rs_if.cdb_in[k].value;
        end
        if (rs_if.cdb_in[k].dest_rob == rs_if.iq_in.src2_rob) begin
          d2_hit = 1'b1;
          d2_val = rs_if.cdb_in[k].value;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (rs_if.cdb_in[k].dest_rob == entries[i].src1_rob) begin
            s1_hit[i] = 1'b1;
            s1_val[i] = rs_if.cdb_in[k].value;
          end
          if (rs_if.cdb_in[k].dest_rob == entries[i].src2_rob) begin
            s2_hit[i] = 1'b1;
            s2_val[i] = rs_if.cdb_in[k].value;
          end
        end
      end
    end
  end

  // Entry image for a new dispatch, with same-cycle CDB forwarding into still-pending sources.
  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.dest_rob   = rs_if.iq_in.dest_rob;
    new_entry.alu_ops    = rs_if.iq_in.alu_ops;
    new_entry.src1_rob   = rs_if.iq_in.src1_rob;
    new_entry.src1_value = rs_if.iq_in.src1_value;
    new_entry.src1_valid = rs_if.iq_in.src1_valid;
    new_entry.src2_rob   = rs_if.iq_in.src2_rob;
    new_entry.src2_value = rs_if.iq_in.src2_value;
    new_entry.src2_valid = rs_if.iq_in.src2_valid;
    if (!rs_if.iq_in.src1_valid && d1_hit) begin
      new_entry.src1_value = d1_val;
      new_entry.src1_valid = 1'b1;
    end
    if (!rs_if.iq_in.src2_valid && d2_hit) begin
      new_entry.src2_value = d2_val;
      new_entry.src2_valid = 1'b1;
    end
  end

  // Entry array and issue register: wakeup, issue and allocation touch disjoint slots in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      alu_out_q <= '0;
    end else if (rs_if.flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
      end
      alu_out_q.ld_alu <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (entries[i].valid) begin
          if (!entries[i].src1_valid && s1_hit[i]) begin
            entries[i].src1_value <= s1_val[i];
            entries[i].src1_valid <= 1'b1;
          end
          if (!entries[i].src2_valid && s2_hit[i]) begin
            entries[i].src2_value <= s2_val[i];
            entries[i].src2_valid <= 1'b1;
          end
        end
      end
      alu_out_q.ld_alu <= 1'b0;
      if (rs_if.alu_ready && ready_found) begin
        alu_out_q <= '{ld_alu:   1'b1,
                       rob_idx:  entries[ready_idx].dest_rob,
                       alu_op:   entries[ready_idx].alu_ops,
                       alu_src1: entries[ready_idx].src1_value,
                       alu_src2: entries[ready_idx].src2_value};
        entries[ready_idx].valid <= 1'b0;
      end
      if (alloc) begin
        entries[free_idx] <= new_entry;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_station.sv
// Bench for alu_rs_station: directed scenarios followed by random traffic, all checked each cycle
// against a behavioural model of the station (slot arrays updated by the dispatch/wakeup/issue rules).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_alu_rs_station;
  import alu_rs_pkg::*;

  localparam int N  = 4;
  localparam int NC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_rs_station_if #(.NUM_CDB(NC)) bus ();

  alu_rs_station #(.NUM_ENTRIES(N), .NUM_CDB(NC), .RS_ID(4'd0)) dut (
    .clk   (clk),
    .rst   (rst),
    .rs_if (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one record per slot plus the last issued op.
  bit          m_v  [N];
  logic [4:0]  m_rob[N];
  logic [2:0]  m_op [N];
  logic [4:0]  m_t1 [N];
  logic [4:0]  m_t2 [N];
  logic [31:0] m_x1 [N];
  logic [31:0] m_x2 [N];
  bit          m_r1 [N];
  bit          m_r2 [N];
  RStoALU      m_out;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m_v[i]) return 1'b0;
    return 1'b1;
  endfunction

  // First broadcasting port carrying this tag, if any.
  function automatic bit cdb_find(input logic [4:0] tag, output logic [31:0] val);
    val = '0;
    for (int k = 0; k < NC; k++) begin
      if (bus.cdb_in[k].valid && bus.cdb_in[k].dest_rob == tag) begin
        val = bus.cdb_in[k].value;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic RStoALU exp_out(input logic [4:0] rob, input logic [2:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
    return '{ld_alu: 1'b1, rob_idx: rob, alu_op: op, alu_src1: a, alu_src2: b};
  endfunction

  // Apply one clock edge worth of station behaviour to the model using the inputs held this cycle.
  task automatic model_update();
    int ri;
    int fi;
    bit hit;
    logic [31:0] v;
    IQtoRS d;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_v[i] = 0; m_rob[i] = '0; m_op[i] = '0; m_t1[i] = '0; m_t2[i] = '0;
        m_x1[i] = '0; m_x2[i] = '0; m_r1[i] = 0; m_r2[i] = 0;
      end
      m_out = '0;
      return;
    end
    if (bus.flush) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_out.ld_alu = 1'b0;
      return;
    end
    ri = -1;
    fi = -1;
    for (int i = 0; i < N; i++) begin
      if (ri < 0 && m_v[i] && m_r1[i] && m_r2[i]) ri = i;
      if (fi < 0 && !m_v[i]) fi = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && !m_r1[i]) begin
        hit = cdb_find(m_t1[i], v);
        if (hit) begin m_x1[i] = v; m_r1[i] = 1; end
      end
      if (m_v[i] && !m_r2[i]) begin
        hit = cdb_find(m_t2[i], v);
        if (hit) begin m_x2[i] = v; m_r2[i] = 1; end
      end
    end
    m_out.ld_alu = 1'b0;
    if (bus.alu_ready && ri >= 0) begin
      m_out = exp_out(m_rob[ri], m_op[ri], m_x1[ri], m_x2[ri]);
      m_v[ri] = 0;
    end
    d = bus.iq_in;
    if (d.load_RS && d.RS_sel == 4'd0 && fi >= 0) begin
      m_v[fi] = 1; m_rob[fi] = d.dest_rob; m_op[fi] = d.alu_ops;
      m_t1[fi] = d.src1_rob; m_x1[fi] = d.src1_value; m_r1[fi] = d.src1_valid;
      m_t2[fi] = d.src2_rob; m_x2[fi] = d.src2_value; m_r2[fi] = d.src2_valid;
      if (!d.src1_valid) begin
        hit = cdb_find(d.src1_rob, v);
        if (hit) begin m_x1[fi] = v; m_r1[fi] = 1; end
      end
      if (!d.src2_valid) begin
        hit = cdb_find(d.src2_rob, v);
        if (hit) begin m_x2[fi] = v; m_r2[fi] = 1; end
      end
    end
  endtask

  // One clock: protocol check, edge, model update, output compare, then drop one-shot inputs.
  task automatic step();
    if (!rst && !bus.flush && bus.iq_in.load_RS && bus.iq_in.RS_sel == 4'd0)
      check("dispatch_while_full", 128'(bus.rs_full), 128'(1'b0));
    @(posedge clk);
    #1;
    model_update();
    check("rs_full", 128'(bus.rs_full), 128'(m_full()));
    check("alu_out", 128'(bus.alu_out), 128'(m_out));
    rst       = 1'b0;
    bus.flush = 1'b0;
    bus.iq_in = '0;
    for (int k = 0; k < NC; k++) bus.cdb_in[k] = '0;
  endtask

  task automatic dispatch(input logic [4:0] rob, input logic [2:0] op,
                          input logic [4:0] t1, input logic [31:0] x1, input logic r1,
                          input logic [4:0] t2, input logic [31:0] x2, input logic r2);
    bus.iq_in = '{load_RS: 1'b1, RS_sel: 4'd0, dest_rob: rob, alu_ops: op,
                  src1_rob: t1, src1_value: x1, src1_valid: r1,
                  src2_rob: t2, src2_value: x2, src2_valid: r2};
  endtask

  task automatic bcast(input int p, input logic [4:0] tag, input logic [31:0] val);
    bus.cdb_in[p] = '{dest_rob: tag, value: val, valid: 1'b1};
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.iq_in     = '0;
    bus.alu_ready = 1'b0;
    for (int k = 0; k < NC; k++) bus.cdb_in[k] = '0;

    // Reset
    rst = 1'b1; step();
    rst = 1'b1; step();
    check("reset_out",  128'(bus.alu_out), 128'(0));
    check("reset_full", 128'(bus.rs_full), 128'(0));

    // Ready-at-dispatch op issues two cycles later as a single pulse
    bus.alu_ready = 1'b1;
    dispatch(5'd5, 3'd0, 5'd0, 32'd10, 1'b1, 5'd0, 32'd20, 1'b1);
    step();
    check("t1_not_yet", 128'(bus.alu_out.ld_alu), 128'(0));
    step();
    check("t1_issue", 128'(bus.alu_out), 128'(exp_out(5'd5, 3'd0, 32'd10, 32'd20)));
    step();
    check("t1_pulse", 128'(bus.alu_out.ld_alu), 128'(0));

    // Wakeup from CDB port 1 two cycles after dispatch
    dispatch(5'd7, 3'd1, 5'd3, 32'd0, 1'b0, 5'd0, 32'd1, 1'b1);
    step();
    step();
    bcast(1, 5'd3, 32'hDEAD);
    step();
    check("t2_early", 128'(bus.alu_out.ld_alu), 128'(0));
    step();
    check("t2_issue", 128'(bus.alu_out), 128'(exp_out(5'd7, 3'd1, 32'hDEAD, 32'd1)));

    // Same-cycle forwarding into a dispatched source
    dispatch(5'd2, 3'd2, 5'd0, 32'd11, 1'b1, 5'd9, 32'd0, 1'b0);
    bcast(0, 5'd9, 32'h55);
    step();
    check("t3_early", 128'(bus.alu_out.ld_alu), 128'(0));
    step();
    check("t3_issue", 128'(bus.alu_out), 128'(exp_out(5'd2, 3'd2, 32'd11, 32'h55)));

    // Fill all slots with waiting ops, wake slot 2 only
    bus.alu_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      dispatch(5'(10 + i), 3'd3, 5'(20 + i), 32'd0, 1'b0, 5'd0, 32'(i), 1'b1);
      step();
    end
    check("t4_full", 128'(bus.rs_full), 128'(1));
    bus.alu_ready = 1'b1;
    bcast(2, 5'd22, 32'h1234);
    step();
    check("t4_still_full", 128'(bus.rs_full), 128'(1));
    step();
    check("t4_issue_slot2", 128'(bus.alu_out), 128'(exp_out(5'd12, 3'd3, 32'h1234, 32'd2)));
    check("t4_freed", 128'(bus.rs_full), 128'(0));
    dispatch(5'd14, 3'd4, 5'd0, 32'd7, 1'b1, 5'd0, 32'd8, 1'b1);
    step();
    check("t4_refill", 128'(bus.rs_full), 128'(1));
    step();
    check("t4_refill_issue", 128'(bus.alu_out), 128'(exp_out(5'd14, 3'd4, 32'd7, 32'd8)));

    // Flush with three waiting entries and a concurrent dispatch
    bus.flush = 1'b1;
    dispatch(5'd15, 3'd5, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1);
    step();
    check("flush_full", 128'(bus.rs_full), 128'(0));
    check("flush_ld",   128'(bus.alu_out.ld_alu), 128'(0));
    bcast(0, 5'd20, 32'h1);
    bcast(1, 5'd21, 32'h2);
    step();
    check("flush_discard", 128'(bus.alu_out.ld_alu), 128'(0));
    step();
    check("flush_no_ghost", 128'(bus.alu_out.ld_alu), 128'(0));

    // Two ready ops held back by alu_ready, then issued in slot order
    bus.alu_ready = 1'b0;
    dispatch(5'd16, 3'd0, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1);
    step();
    dispatch(5'd17, 3'd1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4, 1'b1);
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_hold", 128'(bus.alu_out.ld_alu), 128'(0));
    end
    bus.alu_ready = 1'b1;
    step();
    check("t5_first",  128'(bus.alu_out), 128'(exp_out(5'd16, 3'd0, 32'd1, 32'd2)));
    step();
    check("t5_second", 128'(bus.alu_out), 128'(exp_out(5'd17, 3'd1, 32'd3, 32'd4)));
    step();
    check("t5_done", 128'(bus.alu_out.ld_alu), 128'(0));

    // Reset in the middle of a wakeup
    dispatch(5'd18, 3'd2, 5'd25, 32'd0, 1'b0, 5'd0, 32'd5, 1'b1);
    step();
    bcast(0, 5'd25, 32'hBEEF);
    rst = 1'b1;
    step();
    check("rst_mid_out",  128'(bus.alu_out), 128'(0));
    check("rst_mid_full", 128'(bus.rs_full), 128'(0));
    step();
    step();
    check("rst_mid_no_issue", 128'(bus.alu_out.ld_alu), 128'(0));

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.alu_ready = ($urandom_range(3) != 0);
      if (!m_full() && $urandom_range(1) == 1) begin
        dispatch(5'($urandom_range(31)), 3'($urandom_range(7)),
                 5'($urandom_range(7)), $urandom, 1'($urandom_range(1)),
                 5'($urandom_range(7)), $urandom, 1'($urandom_range(1)));
        if ($urandom_range(7) == 0) bus.iq_in.RS_sel = 4'($urandom_range(15, 1));
      end
      for (int k = 0; k < NC; k++)
        if ($urandom_range(2) == 0) bcast(k, 5'($urandom_range(7)), $urandom);
      if ($urandom_range(49) == 0) bus.flush = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rs_station.md
Name: alu_rs_station

Overview:
- Reservation station for the integer ALU: the receiving end of the IQtoRS dispatch interface and the issuing end of the RStoALU interface.
- Accepts dispatched ops addressed to its RS_ID and holds them in a small entry array.
- Snoops the common data buses (data_bus) to wake pending operands, then issues one ready op per cycle to the ALU.
- Sits between the instruction queue/dispatch stage and the ALU functional unit.

Parameters:
- NUM_ENTRIES, 4, number of station entries (power of 2, 2..16)
- NUM_CDB, 3, number of data_bus broadcast ports snooped (ALU, CMP, LD/ST)
- RS_ID, 4'd0, RS_sel value that selects this station

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous squash of all entries and pending issue
- iq_in  input  IQtoRS (89)  dispatch request: load_RS, RS_sel, dest_rob, alu_ops, src1/src2 rob/value/valid
- rs_full  output  1  no free entry; dispatch must not target this station
- cdb_in  input  data_bus [NUM_CDB] (38 each)  result broadcasts {dest_rob, value, valid}
- alu_ready  input  1  ALU can accept an op this cycle
- alu_out  output  RStoALU (73)  issue: ld_alu, rob_idx, alu_op, alu_src1, alu_src2

Behaviour:
- Entry state: Reservation_st fields used are valid, dest_rob, alu_ops, src1/src2 {rob, value, valid}. Branch and pc fields are held at 0.
- Reset (rst=1): all entry valid=0, every entry field 0, alu_out=0, rs_full=0. Reset overrides flush and dispatch.
- rs_full = AND of entry valid bits. It is registered state only; a slot freed in cycle t shows as not-full in cycle t+1.
- Allocate condition: iq_in.load_RS && iq_in.RS_sel==RS_ID && !rs_full.
  - Write the lowest-index free entry.
  - Dispatch while rs_full: the request is dropped. Bench flags this as a protocol error.
- Dispatch-cycle forwarding: if a source has srcN_valid=0 and some cdb_in[k].valid && dest_rob==srcN_rob in the same cycle, store the entry with that value and srcN_valid=1.
- Wakeup, every cycle for each valid entry with srcN_valid=0: on a matching valid CDB port, latch value and set srcN_valid=1.
  - Multiple matching ports: lowest port index wins.
  - Both operands may wake in the same cycle.
- Ready means valid && src1_valid && src2_valid, evaluated on registered entry state. An entry woken in cycle t is first eligible in cycle t+1.
- Issue (registered, 1-cycle latency):
  - If alu_ready and any entry is ready, select the lowest-index ready entry.
  - Next cycle alu_out = {1, dest_rob, alu_ops, src1_value, src2_value}, and that entry's valid is cleared on the same edge.
  - Otherwise alu_out.ld_alu=0 next cycle; the other alu_out fields hold their last values.
  - ld_alu is a single-cycle pulse per op; at most one issue per cycle.
- alu_ready=0: no issue and no entry freed. Entries keep waking.
- Simultaneous issue and allocate in one cycle:
  - Allocation uses free slots from registered state, so it cannot target the entry being issued.
  - The issued slot becomes free next cycle.
- Flush: next cycle all entries invalid, alu_out.ld_alu=0, rs_full=0. A dispatch in the flush cycle is discarded.
- ROB tag 0 is a legal tag; no special meaning.
- All arithmetic is comparison only; values are stored unmodified, 32 bits.
- Implementation: one always_ff for entries and alu_out, plus combinational priority encoders for free slot, ready slot and CDB match.

Test Plan:
- Dispatch RS_sel=RS_ID, dest_rob=5, alu_ops=3'b000, src1=10 valid, src2=20 valid, alu_ready=1 -> next cycle entry0 valid; following cycle alu_out={ld_alu=1, rob_idx=5, alu_op=0, src1=10, src2=20}; ld_alu=0 after.
- Dispatch dest_rob=7 with src1_rob=3 invalid, src2=1 valid; two cycles later cdb_in[1]={dest_rob=3, value=32'hDEAD, valid=1} -> issue exactly 2 cycles after the broadcast with alu_src1=32'hDEAD, rob_idx=7.
- Dispatch with src2_rob=9 invalid while cdb_in[0]={9, 32'h55, 1} in the same cycle -> entry stored ready; issues 2 cycles after dispatch with alu_src2=32'h55.
- Fill 4 entries, none ready -> rs_full=1. Wake entry2 -> it issues first. rs_full=0 the cycle after issue, and the next dispatch lands in slot 2.
- Two entries ready with alu_ready=0 for 3 cycles -> no ld_alu. Raise alu_ready -> lowest index issues, then the other in the next cycle.
- With 3 entries valid, assert flush with a concurrent dispatch -> next cycle no entries, rs_full=0, no ld_alu. Likewise rst mid-wakeup -> all outputs 0.
